// File: rtl/req_pending_tracker_pkg.sv
// Shared types and round-robin helpers for the request pending tracker.
package req_pending_tracker_pkg;

    typedef enum logic [1:0] {IDLE, SEL, OFFER} state_t;

    // Helpers operate on a fixed maximum width; callers zero-extend narrower vectors.
    localparam int MAX_REQ = 16;
    localparam int MAX_W   = 4;

    // First set bit at or after ptr, wrapping at n, returned one-hot.
    function automatic logic [MAX_REQ-1:0] rr_onehot(input logic [MAX_REQ-1:0] pend,
                                                     input int ptr, input int n);
        logic [MAX_REQ-1:0] r;
        logic               found;
        int                 idx;
        r     = '0;
        found = 1'b0;
        for (int k = 0; k < MAX_REQ; k++) begin
            if (k < n) begin
                idx = ptr + k;
                if (idx >= n) idx = idx - n;
                if (!found && pend[idx[MAX_W-1:0]]) begin
                    r[idx[MAX_W-1:0]] = 1'b1;
                    found = 1'b1;
                end
            end
        end
        return r;
    endfunction

    function automatic int onehot_idx(input logic [MAX_REQ-1:0] oh);
        int i;
        i = 0;
        for (int k = 0; k < MAX_REQ; k++)
            if (oh[k]) i = k;
        return i;
    endfunction

endpackage

// File: rtl/req_pending_tracker_rr_pick.sv
// Combinational round-robin pick: first pending channel at or after ptr.
module rr_pick
    import req_pending_tracker_pkg::*;
#(
    parameter int NUM_REQ = 3,
    parameter int IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] pend,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] onehot,
    output logic [IDX_W-1:0]   idx
);

    logic [MAX_REQ-1:0] wide;

    always_comb begin
        wide   = rr_onehot(MAX_REQ'(pend), int'(ptr), NUM_REQ);
        onehot = wide[NUM_REQ-1:0];
        idx    = IDX_W'(onehot_idx(wide));
    end

endmodule

// File: rtl/req_pending_tracker.sv
// Sticky request capture with round-robin one-hot offer under valid/ready,
// plus overflow and stall-timeout flags.
module req_pending_tracker
    import req_pending_tracker_pkg::*;
#(
    parameter int NUM_REQ = 3,
    parameter int TMO_W   = 4,
    parameter int TMO_MAX = 15
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req_in,
    output logic [NUM_REQ-1:0] out_vec,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [NUM_REQ-1:0] pend_o,
    output logic [NUM_REQ-1:0] ovf_o,
    output logic               stall_err,
    input  logic               err_clr
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    state_t             state;
    logic [NUM_REQ-1:0] pend, pick, offering, ovf_evt, pend_nxt;
    logic [IDX_W-1:0]   ptr, sel_idx, pick_idx;
    logic [TMO_W-1:0]   tmo_cnt;
    logic               hs, stall_evt;

    rr_pick #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_pick (
        .pend   (pend),
        .ptr    (ptr),
        .onehot (pick),
        .idx    (pick_idx)
    );

    assign pend_o = pend;

    always_comb begin
        hs        = out_valid && out_ready;
        // A request for the channel completing its handshake is a fresh request, not an overflow.
        offering  = out_vec & {NUM_REQ{~hs}};
        ovf_evt   = req_in & (pend | offering);
        pend_nxt  = (pend & ~((state == SEL) ? pick : '0)) | req_in;
        stall_evt = (state == OFFER) && !hs && (tmo_cnt == TMO_W'(TMO_MAX - 1));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            pend      <= '0;
            out_vec   <= '0;
            out_valid <= 1'b0;
            ovf_o     <= '0;
            stall_err <= 1'b0;
            ptr       <= '0;
            sel_idx   <= '0;
            tmo_cnt   <= '0;
        end else begin
            pend      <= pend_nxt;
            ovf_o     <= ovf_evt | (ovf_o & ~{NUM_REQ{err_clr}});
            stall_err <= stall_evt | (stall_err & ~err_clr);
            case (state)
                IDLE: begin
                    tmo_cnt <= '0;
                    if (|pend_nxt) state <= SEL;
                end
                SEL: begin
                    sel_idx   <= pick_idx;
                    out_vec   <= pick;
                    out_valid <= 1'b1;
                    tmo_cnt   <= '0;
                    state     <= OFFER;
                end
                OFFER: begin
                    if (hs) begin
                        ptr       <= (sel_idx == IDX_W'(NUM_REQ - 1)) ? '0 : sel_idx + 1'b1;
                        out_vec   <= '0;
                        out_valid <= 1'b0;
                        tmo_cnt   <= '0;
                        state     <= (|pend_nxt) ? SEL : IDLE;
                    end else if (tmo_cnt != TMO_W'(TMO_MAX)) begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_req_pending_tracker.sv
// Randomized + directed bench for req_pending_tracker with a channel-level reference model.
module tb_req_pending_tracker;

    localparam int N    = 3;
    localparam int TMAX = 15;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [N-1:0] req_in = '0;
    logic         out_ready = 1'b0;
    logic         err_clr = 1'b0;
    logic [N-1:0] out_vec, pend_o, ovf_o;
    logic         out_valid, stall_err;

    req_pending_tracker #(.NUM_REQ(N), .TMO_W(4), .TMO_MAX(TMAX)) dut (
        .clk(clk), .rst(rst), .req_in(req_in), .out_vec(out_vec), .out_valid(out_valid),
        .out_ready(out_ready), .pend_o(pend_o), .ovf_o(ovf_o), .stall_err(stall_err),
        .err_clr(err_clr)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model: set of pending channels, channel on offer (-1 none), selecting flag, pointer, wait count.
    bit m_pend[N];
    bit m_ovf[N];
    bit m_stall;
    bit m_sel;
    int m_offer;
    int m_ptr;
    int m_wait;

    function automatic void model_reset();
        for (int i = 0; i < N; i++) begin m_pend[i] = 0; m_ovf[i] = 0; end
        m_stall = 0; m_sel = 0; m_offer = -1; m_ptr = 0; m_wait = 0;
    endfunction

    function automatic void model_advance(input logic [N-1:0] r, input bit rdy, input bit clr);
        bit hs, any;
        int nof, pick;
        hs = (m_offer >= 0) && rdy;
        if (clr) begin
            for (int i = 0; i < N; i++) m_ovf[i] = 0;
            m_stall = 0;
        end
        for (int i = 0; i < N; i++)
            if (r[i] && (m_pend[i] || (m_offer == i && !hs))) m_ovf[i] = 1;
        if (m_offer >= 0 && !hs && m_wait == TMAX - 1) m_stall = 1;
        nof = m_offer;
        if (m_sel) begin
            pick = -1;
            for (int k = 0; k < N; k++)
                if (pick < 0 && m_pend[(m_ptr + k) % N]) pick = (m_ptr + k) % N;
            m_pend[pick] = 0;
            nof = pick;
        end
        if (hs) begin
            m_ptr = (m_offer + 1) % N;
            nof = -1;
            m_wait = 0;
        end else if (m_offer >= 0 && m_wait < TMAX) begin
            m_wait++;
        end
        any = 0;
        for (int i = 0; i < N; i++) begin
            if (r[i]) m_pend[i] = 1;
            any |= m_pend[i];
        end
        m_sel = (((m_offer < 0) && !m_sel) || hs) && any;
        m_offer = nof;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic compare_model();
        logic [N-1:0] ev, ep, eo;
        ev = '0; ep = '0; eo = '0;
        if (m_offer >= 0) ev[m_offer] = 1'b1;
        for (int i = 0; i < N; i++) begin ep[i] = m_pend[i]; eo[i] = m_ovf[i]; end
        chk("out_valid", int'(out_valid), int'(m_offer >= 0));
        chk("out_vec", int'(out_vec), int'(ev));
        chk("pend_o", int'(pend_o), int'(ep));
        chk("ovf_o", int'(ovf_o), int'(eo));
        chk("stall_err", int'(stall_err), int'(m_stall));
    endtask

    // Called at a falling edge: drive, advance model across the next rising edge, compare at next falling edge.
    task automatic step(input logic [N-1:0] r, input bit rdy, input bit clr);
        req_in = r; out_ready = rdy; err_clr = clr;
        model_advance(r, rdy, clr);
        @(negedge clk);
        compare_model();
    endtask

    task automatic do_reset();
        rst = 1'b1; req_in = '0; out_ready = 1'b0; err_clr = 1'b0;
        model_reset();
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        compare_model();
    endtask

    initial begin
        model_reset();
        do_reset();
        chk("reset out_valid", int'(out_valid), 0);
        chk("reset out_vec", int'(out_vec), 0);
        chk("reset ovf", int'(ovf_o), 0);

        // Single request: offer on cycle 2, handshake, back to idle.
        step(3'b001, 1, 0);
        step(3'b000, 1, 0);
        chk("t1 valid@2", int'(out_valid), 1);
        chk("t1 vec@2", int'(out_vec), 3'b001);
        step(3'b000, 1, 0);
        chk("t1 done", int'(out_valid), 0);
        chk("t1 ovf", int'(ovf_o), 0);

        // Three at once from ptr=0: grants on cycles 2, 4, 6.
        do_reset();
        step(3'b111, 1, 0);
        step(3'b000, 1, 0);
        chk("t2 g0", int'(out_vec), 3'b001);
        step(3'b000, 1, 0);
        step(3'b000, 1, 0);
        chk("t2 g1", int'(out_vec), 3'b010);
        step(3'b000, 1, 0);
        step(3'b000, 1, 0);
        chk("t2 g2", int'(out_vec), 3'b100);
        chk("t2 pend", int'(pend_o), 0);
        step(3'b000, 1, 0);

        // ptr=1 after granting ch0, then 101 grants ch2 before ch0.
        step(3'b001, 1, 0);
        step(3'b000, 1, 0);
        step(3'b000, 1, 0);
        step(3'b101, 1, 0);
        step(3'b000, 1, 0);
        chk("t3 wrap first", int'(out_vec), 3'b100);
        step(3'b000, 1, 0);
        step(3'b000, 1, 0);
        chk("t3 wrap second", int'(out_vec), 3'b001);
        step(3'b000, 1, 0);

        // Stall: offer ch1 unacknowledged for 20 cycles.
        step(3'b010, 0, 0);
        step(3'b000, 0, 0);
        chk("t4 offer", int'(out_vec), 3'b010);
        for (int k = 1; k <= 20; k++) begin
            step(3'b000, 0, 0);
            chk("t4 held", int'(out_vec), 3'b010);
            chk("t4 stall", int'(stall_err), int'(k >= TMAX));
        end
        step(3'b000, 0, 1);
        chk("t4 clr", int'(stall_err), 0);
        step(3'b000, 1, 0);
        chk("t4 hs", int'(out_valid), 0);

        // Overflow on ch1 while pending; re-request on its handshake is a fresh grant.
        do_reset();
        step(3'b001, 0, 0);
        step(3'b000, 0, 0);
        step(3'b010, 0, 0);
        step(3'b000, 0, 0);
        step(3'b010, 0, 0);
        chk("t5 ovf", int'(ovf_o), 3'b010);
        step(3'b000, 1, 0);
        step(3'b000, 0, 0);
        chk("t5 ch1 offer", int'(out_vec), 3'b010);
        step(3'b010, 1, 0);
        chk("t5 repend", int'(pend_o), 3'b010);
        chk("t5 ovf kept", int'(ovf_o), 3'b010);
        step(3'b000, 1, 0);
        chk("t5 ch1 again", int'(out_vec), 3'b010);
        step(3'b000, 1, 0);
        chk("t5 idle pend", int'(pend_o), 0);

        // Async reset mid-offer with pend=101.
        do_reset();
        step(3'b110, 0, 0);
        step(3'b000, 0, 0);
        step(3'b001, 0, 0);
        chk("t6 offer", int'(out_vec), 3'b010);
        chk("t6 pend", int'(pend_o), 3'b101);
        rst = 1'b1;
        #1;
        model_reset();
        chk("t6 rst valid", int'(out_valid), 0);
        chk("t6 rst vec", int'(out_vec), 0);
        chk("t6 rst pend", int'(pend_o), 0);
        @(negedge clk);
        rst = 1'b0; req_in = '0;
        for (int k = 0; k < 4; k++) begin
            step(3'b000, 1, 0);
            chk("t6 quiet", int'(out_valid), 0);
        end

        // Random traffic: a busy phase and a back-pressured phase.
        for (int k = 0; k < 3000; k++) begin
            logic [N-1:0] r;
            bit rdy;
            r   = ($urandom_range(0, 3) == 0) ? N'($urandom_range(1, 7)) : '0;
            rdy = (k < 1500) ? ($urandom_range(0, 2) != 0) : ($urandom_range(0, 24) == 0);
            step(r, rdy, $urandom_range(0, 29) == 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
